// File: rtl/mcu_pkg.sv
// Shared MCU types and constants used by the fetch stage.
package mcu_pkg;

    localparam int unsigned IR_W         = 32;
    localparam int unsigned DEF_RESET_PC = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        ACCEPT,
        BUSY,
        PFWAIT
    } fetch_state_t;

endpackage

// File: rtl/prefetch_buf.sv
// Single-entry prefetch buffer; flush beats load, load beats consume.
module prefetch_buf
    import mcu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            consume,
    input  logic            flush,
    input  logic [IR_W-1:0] din,
    output logic [IR_W-1:0] pbuf,
    output logic            pbuf_v
);

    // Buffer word and valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pbuf   <= '0;
            pbuf_v <= 1'b0;
        end else if (flush) begin
            pbuf_v <= 1'b0;
        end else if (load) begin
            pbuf   <= din;
            pbuf_v <= 1'b1;
        end else if (consume) begin
            pbuf_v <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, issues to the decoder.
module fetch_unit
    import mcu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [IR_W-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic [IR_W-1:0]   ir,
    output logic              cs,
    input  logic              dec_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_t      state, state_d;
    logic [ADDR_W-1:0] pc_d, pc_eff, addr_d;
    logic [IR_W-1:0]   ir_d, pbuf;
    logic              cs_d, req_d, stale, stale_d;
    logic              pbuf_v, pb_load, pb_consume, pb_flush;
    logic              ack, keep;

    prefetch_buf u_pbuf (
        .clk     (clk),
        .rst     (rst),
        .load    (pb_load),
        .consume (pb_consume),
        .flush   (pb_flush),
        .din     (mem_rdata),
        .pbuf    (pbuf),
        .pbuf_v  (pbuf_v)
    );

    // Next-state, next-PC and handshake decisions.
    always_comb begin
        pc_eff     = pc_load ? pc_target : pc;
        ack        = mem_req && mem_ack;
        // A word is kept only if it was not made stale by a branch, including one this cycle.
        keep       = ack && !stale && !pc_load;
        state_d    = state;
        pc_d       = pc_eff;
        ir_d       = ir;
        cs_d       = 1'b0;
        req_d      = mem_req;
        addr_d     = mem_addr;
        stale_d    = stale;
        pb_load    = 1'b0;
        pb_consume = 1'b0;
        pb_flush   = pc_load;

        if (ack) begin
            req_d   = 1'b0;
            stale_d = 1'b0;
        end
        if (pc_load && mem_req && !mem_ack) begin
            stale_d = 1'b1;
        end

        case (state)
            IDLE: begin
                if (en) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_eff;
                end
            end
            FETCH: begin
                if (keep) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc + ADDR_W'(1);
                    cs_d    = 1'b1;
                    state_d = ISSUE;
                end else if (!mem_req) begin
                    if (en) begin
                        req_d  = 1'b1;
                        addr_d = pc_eff;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ISSUE: begin
                state_d = ACCEPT;
            end
            ACCEPT: begin
                // X/Z on dec_ready falls into the else branch and counts as busy.
                if (dec_ready) state_d = ACCEPT;
                else           state_d = BUSY;
            end
            BUSY: begin
                if (dec_ready) begin
                    if (pbuf_v && !pc_load) begin
                        ir_d       = pbuf;
                        pb_consume = 1'b1;
                        cs_d       = 1'b1;
                        state_d    = ISSUE;
                    end else if (keep) begin
                        ir_d    = mem_rdata;
                        pc_d    = pc + ADDR_W'(1);
                        cs_d    = 1'b1;
                        state_d = ISSUE;
                    end else if (mem_req && !mem_ack) begin
                        state_d = PFWAIT;
                    end else if (ack) begin
                        // Stale ack just retired; req must stay low a cycle before the next fetch.
                        state_d = FETCH;
                    end else if (en) begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_eff;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (keep) begin
                        pb_load = 1'b1;
                        pc_d    = pc + ADDR_W'(1);
                    end else if (en && !pbuf_v && !mem_req) begin
                        req_d  = 1'b1;
                        addr_d = pc_eff;
                    end
                end
            end
            PFWAIT: begin
                if (keep) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc + ADDR_W'(1);
                    cs_d    = 1'b1;
                    state_d = ISSUE;
                end else if (ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= ADDR_W'(RESET_PC);
            ir       <= '0;
            cs       <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= ADDR_W'(RESET_PC);
            stale    <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            ir       <= ir_d;
            cs       <= cs_d;
            mem_req  <= req_d;
            mem_addr <= addr_d;
            stale    <= stale_d;
        end
    end

endmodule
